gpio_irq_ctrl: RTL and testbench
================================

Name: gpio_irq_ctrl

Overview:
- Second-generation general-purpose I/O peripheral on the Cortex-M0 AHB-lite decode fabric, using the same sel/read/write slave strobes as existing peripherals.
- Adds per-pin direction, an output toggle register, and per-pin rising/falling edge interrupt selection.
- Adds a sticky write-1-to-clear interrupt status and a masked, registered irq line to the NVIC.
- Input synchroniser depth is parametrised.

Parameters:
- DATA_WIDTH, 16, number of pins (1..32); register bits above DATA_WIDTH read 0, writes ignored.
- SYNC_STAGES, 2, input synchroniser flops per pin (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sel  input  1  peripheral select from address decoder
- read  input  1  read strobe (valid with sel)
- write  input  1  write strobe (valid with sel)
- addr  input  3  word index of register (bus address bits [4:2])
- wdata  input  32  write data; bits [DATA_WIDTH-1:0] used
- gpin  input  DATA_WIDTH  asynchronous pad inputs
- rdata  output  32  read data, zero-extended
- gpout  output  DATA_WIDTH  output data to pads
- gpoe  output  DATA_WIDTH  per-pin output enable (1 = drive)
- irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset (async, active-high) clears all flops to 0: synchroniser chain, edge-history register, OUT, DIR, IEN, RISE, FALL, STATUS and irq. Consequences: gpout=0, gpoe=0 (all pins inputs), irq=0.
- Register map (addr):
  - 0 IN: RO, last synchroniser stage.
  - 1 OUT: RW, drives gpout.
  - 2 DIR: RW, drives gpoe.
  - 3 IEN: RW, interrupt mask.
  - 4 RISE: RW, rising-edge enable.
  - 5 FALL: RW, falling-edge enable.
  - 6 STATUS: R/W1C.
  - 7 TOGGLE: WO, reads 0; a write XORs wdata into OUT.
- Writes take effect on the clk edge where sel & write = 1. Writes to IN are ignored.
- rdata is combinational: selected register when sel & read, else 32'h0. Reads have no side effects.
- Synchroniser: s[0] <= gpin, s[k] <= s[k-1]; IN = s[SYNC_STAGES-1]. History register h <= IN every cycle.
- Edge detect (combinational):
  - rise = IN & ~h & RISE
  - fall = ~IN & h & FALL
  - ev = rise | fall
- Both RISE and FALL set for a pin = any-edge mode.
- STATUS update each cycle: STATUS <= (STATUS & ~w1c) | ev, where w1c = wdata when sel & write & addr==6, else 0.
  - Set wins over a simultaneous clear on the same bit.
  - STATUS latches events regardless of IEN.
- irq <= |(STATUS & IEN), registered. Setting IEN on an already-pending bit raises irq one cycle later.
- Latency, with gpin changing before edge E1 and SYNC_STAGES=S:
  - IN updates at E_S.
  - STATUS bit set at E_{S+1}.
  - irq high at E_{S+2}.
  - For S=2: irq high at the 4th edge after the change.
- Clear latency: after a W1C write on edge E (no new event), STATUS clears at E and irq falls at E+1.
- Pin pulses shorter than one clk period may be missed; this is an accepted limitation and no filtering is performed.
- gpout/gpoe are independent of IN; pins configured as outputs still synchronise and can interrupt on the pad value.
- Reset asserted mid-operation aborts any pending status immediately. Edges occurring during reset are not reported; h and IN leave reset at 0.

Decomposition:
- Package gpio_pkg: register index constants (GPIO_IN=0 … GPIO_TOGGLE=7) and REG_IDX_W=3; shared with firmware header generation.
- Sub-module gpio_sync_edge #(WIDTH, STAGES): synchroniser chain, history register and raw rise/fall vectors. The top level applies the RISE/FALL masks and holds registers, STATUS and the bus logic.

Test Plan:
- Reset: assert reset mid-run with OUT=16'hFFFF, STATUS=16'h0003 -> gpout=0, gpoe=0, irq=0, all register reads 0 during and after reset.
- Output path: write OUT=16'hA5A5, DIR=16'h00FF; write TOGGLE=16'h0F0F -> gpout=16'hAAAA, gpoe=16'h00FF; read addr 1 = 32'h0000AAAA; read addr 7 = 0.
- Rising IRQ latency: IEN=RISE=16'h0001; gpin[0] 0->1 before edge E1 -> STATUS=1 at E3, irq=1 at E4; gpin[0] 1->0 -> STATUS unchanged.
- Any-edge and masking: RISE=FALL=16'h0010, IEN=0; toggle gpin[4] -> STATUS=16'h0010, irq stays 0; write IEN=16'h0010 -> irq=1 the next cycle.
- W1C race: STATUS=16'h0003; write STATUS=16'h0003 in the same cycle a new rise on pin 1 is detected -> STATUS=16'h0002, irq stays 1. A second W1C of 16'h0002 -> STATUS=0, irq=0 one cycle later.
- Width corner: DATA_WIDTH=32 and DATA_WIDTH=1 builds; write 32'hFFFFFFFF to OUT -> readback is 32'hFFFFFFFF and 32'h00000001 respectively.

Source files
------------

// File: rtl/gpio_pkg.sv
// GPIO peripheral register index constants, shared with firmware header generation.
package gpio_pkg;

  localparam int unsigned REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] GPIO_IN     = 3'd0;
  localparam logic [REG_IDX_W-1:0] GPIO_OUT    = 3'd1;
  localparam logic [REG_IDX_W-1:0] GPIO_DIR    = 3'd2;
  localparam logic [REG_IDX_W-1:0] GPIO_IEN    = 3'd3;
  localparam logic [REG_IDX_W-1:0] GPIO_RISE   = 3'd4;
  localparam logic [REG_IDX_W-1:0] GPIO_FALL   = 3'd5;
  localparam logic [REG_IDX_W-1:0] GPIO_STATUS = 3'd6;
  localparam logic [REG_IDX_W-1:0] GPIO_TOGGLE = 3'd7;

endpackage : gpio_pkg

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser, one-cycle edge history and raw rise/fall detection.
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_in,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_hist;

  // Synchroniser chain plus history of the synchronised value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) r_sync[k] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int unsigned k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_in   = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_hist;
  assign o_fall = ~r_sync[STAGES-1] & r_hist;

endmodule : gpio_sync_edge

// File: rtl/gpio_irq_ctrl.sv
// GPIO peripheral: direction/output/toggle registers, edge interrupts with W1C status.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  read,
  input  logic                  write,
  input  logic [REG_IDX_W-1:0]  addr,
  input  logic [31:0]           wdata,
  input  logic [DATA_WIDTH-1:0] gpin,
  output logic [31:0]           rdata,
  output logic [DATA_WIDTH-1:0] gpout,
  output logic [DATA_WIDTH-1:0] gpoe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_ien;
  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_fall;
  logic [DATA_WIDTH-1:0] r_status;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_in;
  logic [DATA_WIDTH-1:0] w_rise_raw;
  logic [DATA_WIDTH-1:0] w_fall_raw;
  logic [DATA_WIDTH-1:0] w_ev;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_w1c;
  logic                  w_wr;

  gpio_sync_edge #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (gpin),
    .o_in   (w_in),
    .o_rise (w_rise_raw),
    .o_fall (w_fall_raw)
  );

  assign w_wr    = sel & write;
  assign w_wdata = wdata[DATA_WIDTH-1:0];
  assign w_ev    = (w_rise_raw & r_rise) | (w_fall_raw & r_fall);
  assign w_w1c   = (w_wr && (addr == GPIO_STATUS)) ? w_wdata : '0;

  // Upper write-data bits are deliberately ignored on narrow builds
  if (DATA_WIDTH < 32) begin : g_unused
    logic w_unused;
    assign w_unused = ^wdata[31:DATA_WIDTH];
  end

  // Bus-writable registers, sticky status (set beats clear) and registered irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_ien    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr) begin
        case (addr)
          GPIO_OUT:    r_out  <= w_wdata;
          GPIO_DIR:    r_dir  <= w_wdata;
          GPIO_IEN:    r_ien  <= w_wdata;
          GPIO_RISE:   r_rise <= w_wdata;
          GPIO_FALL:   r_fall <= w_wdata;
          GPIO_TOGGLE: r_out  <= r_out ^ w_wdata;
          default:     ;
        endcase
      end
      r_status <= (r_status & ~w_w1c) | w_ev;
      r_irq    <= |(r_status & r_ien);
    end
  end

  // Combinational read mux, zero when not addressed
  always_comb begin
    rdata = 32'h0;
    if (sel && read) begin
      case (addr)
        GPIO_IN:     rdata = 32'(w_in);
        GPIO_OUT:    rdata = 32'(r_out);
        GPIO_DIR:    rdata = 32'(r_dir);
        GPIO_IEN:    rdata = 32'(r_ien);
        GPIO_RISE:   rdata = 32'(r_rise);
        GPIO_FALL:   rdata = 32'(r_fall);
        GPIO_STATUS: rdata = 32'(r_status);
        default:     rdata = 32'h0;
      endcase
    end
  end

  assign gpout = r_out;
  assign gpoe  = r_dir;
  assign irq   = r_irq;

endmodule : gpio_irq_ctrl

// File: tb/tb_gpio_irq_ctrl.sv
// Directed self-checking bench for gpio_irq_ctrl (16-bit main instance plus 32/1-bit builds).
module tb_gpio_irq_ctrl;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        rd;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [15:0] gpin;
  logic [31:0] rdata;
  logic [15:0] gpout;
  logic [15:0] gpoe;
  logic        irq;

  logic [31:0] gpin32;
  logic [31:0] rdata32;
  logic [31:0] gpout32;
  logic [31:0] gpoe32;
  logic        irq32;

  logic [0:0]  gpin1;
  logic [31:0] rdata1;
  logic [0:0]  gpout1;
  logic [0:0]  gpoe1;
  logic        irq1;

  int n_pass;
  int n_total;

  gpio_irq_ctrl #(.DATA_WIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .sel(sel), .read(rd), .write(wr), .addr(addr),
    .wdata(wdata), .gpin(gpin), .rdata(rdata), .gpout(gpout), .gpoe(gpoe), .irq(irq)
  );

  gpio_irq_ctrl #(.DATA_WIDTH(32), .SYNC_STAGES(2)) u_dut32 (
    .clk(clk), .reset(reset), .sel(sel), .read(rd), .write(wr), .addr(addr),
    .wdata(wdata), .gpin(gpin32), .rdata(rdata32), .gpout(gpout32), .gpoe(gpoe32), .irq(irq32)
  );

  gpio_irq_ctrl #(.DATA_WIDTH(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset(reset), .sel(sel), .read(rd), .write(wr), .addr(addr),
    .wdata(wdata), .gpin(gpin1), .rdata(rdata1), .gpout(gpout1), .gpoe(gpoe1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end just after a falling edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = rdata;
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    if (gpout !== 16'h0 || gpoe !== 16'h0 || irq !== 1'b0) begin
      $display("FAIL reset_init: gpout=%h gpoe=%h irq=%b, want 0/0/0", gpout, gpoe, irq);
    end else n_pass++;
    n_total++;
    bus_write(3'd1, 32'hFFFF);
    bus_write(3'd2, 32'hFFFF);
    bus_write(3'd4, 32'h0003);
    bus_write(3'd3, 32'h0003);
    gpin = 16'h0003;
    repeat (4) @(negedge clk);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL reset_pre_status: got %h want 00000003", d);
    else n_pass++;
    n_total++;
    if (irq !== 1'b1) $display("FAIL reset_pre_irq: got %b want 1", irq);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (gpout !== 16'h0 || gpoe !== 16'h0 || irq !== 1'b0)
      $display("FAIL reset_mid: gpout=%h gpoe=%h irq=%b, want 0/0/0", gpout, gpoe, irq);
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      n_total++;
      if (d !== 32'h0) $display("FAIL reset_read_during addr=%0d: got %h want 0", a, d);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    gpin  = 16'h0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      n_total++;
      if (d !== 32'h0) $display("FAIL reset_read_after addr=%0d: got %h want 0", a, d);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_output_path();
    logic [31:0] d;
    bus_write(3'd1, 32'hA5A5);
    bus_write(3'd2, 32'h00FF);
    bus_write(3'd7, 32'h0F0F);
    n_total++;
    if (gpout !== 16'hAAAA) $display("FAIL out_gpout: got %h want aaaa", gpout);
    else n_pass++;
    n_total++;
    if (gpoe !== 16'h00FF) $display("FAIL out_gpoe: got %h want 00ff", gpoe);
    else n_pass++;
    bus_read(3'd1, d);
    n_total++;
    if (d !== 32'h0000AAAA) $display("FAIL out_read_out: got %h want 0000aaaa", d);
    else n_pass++;
    bus_read(3'd7, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL out_read_toggle: got %h want 0", d);
    else n_pass++;
    bus_read(3'd2, d);
    n_total++;
    if (d !== 32'h000000FF) $display("FAIL out_read_dir: got %h want 000000ff", d);
    else n_pass++;
    bus_write(3'd0, 32'h1234);
    bus_read(3'd0, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL out_in_ro: got %h want 0", d);
    else n_pass++;
  endtask

  task automatic test_rise_latency();
    logic [31:0] d;
    logic [31:0] exp_status [4];
    logic        exp_irq    [4];
    exp_status = '{32'h0, 32'h0, 32'h1, 32'h1};
    exp_irq    = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus_write(3'd3, 32'h0001);
    bus_write(3'd4, 32'h0001);
    gpin[0] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      bus_read(3'd6, d);
      n_total++;
      if (d !== exp_status[e] || irq !== exp_irq[e])
        $display("FAIL rise_E%0d: status=%h irq=%b want %h/%b", e + 1, d, irq, exp_status[e], exp_irq[e]);
      else n_pass++;
    end
    gpin[0] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h1 || irq !== 1'b1) $display("FAIL rise_fall_ignored: status=%h irq=%b want 1/1", d, irq);
    else n_pass++;
    bus_write(3'd6, 32'h0001);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h0 || irq !== 1'b1) $display("FAIL rise_clear_E: status=%h irq=%b want 0/1", d, irq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) $display("FAIL rise_clear_E1: irq=%b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_any_edge_mask();
    logic [31:0] d;
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'h0010);
    bus_write(3'd5, 32'h0010);
    gpin[4] = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h10 || irq !== 1'b0) $display("FAIL any_rise: status=%h irq=%b want 10/0", d, irq);
    else n_pass++;
    bus_write(3'd6, 32'h0010);
    gpin[4] = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h10 || irq !== 1'b0) $display("FAIL any_fall: status=%h irq=%b want 10/0", d, irq);
    else n_pass++;
    bus_write(3'd3, 32'h0010);
    n_total++;
    if (irq !== 1'b0) $display("FAIL mask_ien_same: irq=%b want 0", irq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) $display("FAIL mask_ien_next: irq=%b want 1", irq);
    else n_pass++;
    bus_write(3'd6, 32'h0010);
    bus_write(3'd5, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back_w1c();
    logic [31:0] d;
    bus_write(3'd3, 32'h0003);
    bus_write(3'd4, 32'h0003);
    gpin[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    gpin[1] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h3 || irq !== 1'b1) $display("FAIL race_setup: status=%h irq=%b want 3/1", d, irq);
    else n_pass++;
    gpin[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(3'd6, 32'h0003);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h2 || irq !== 1'b1) $display("FAIL race_set_wins: status=%h irq=%b want 2/1", d, irq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) $display("FAIL race_irq_held: irq=%b want 1", irq);
    else n_pass++;
    bus_write(3'd6, 32'h0002);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h0 || irq !== 1'b1) $display("FAIL race_clear2: status=%h irq=%b want 0/1", d, irq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) $display("FAIL race_irq_fall: irq=%b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_width_corner();
    logic [31:0] d16;
    logic [31:0] d32;
    logic [31:0] d1;
    bus_write(3'd1, 32'hFFFFFFFF);
    sel = 1'b1; rd = 1'b1; addr = 3'd1;
    #1;
    d16 = rdata; d32 = rdata32; d1 = rdata1;
    sel = 1'b0; rd = 1'b0;
    n_total++;
    if (d32 !== 32'hFFFFFFFF) $display("FAIL width32_out: got %h want ffffffff", d32);
    else n_pass++;
    n_total++;
    if (d1 !== 32'h00000001) $display("FAIL width1_out: got %h want 00000001", d1);
    else n_pass++;
    n_total++;
    if (d16 !== 32'h0000FFFF) $display("FAIL width16_out: got %h want 0000ffff", d16);
    else n_pass++;
    n_total++;
    if (gpout1 !== 1'b1 || gpout32 !== 32'hFFFFFFFF)
      $display("FAIL width_gpout: w1=%b w32=%h want 1/ffffffff", gpout1, gpout32);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'h0;
    gpin = 16'h0; gpin32 = 32'h0; gpin1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_output_path();
    test_rise_latency();
    test_any_edge_mask();
    test_back_to_back_w1c();
    test_width_corner();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_gpio_irq_ctrl
